// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the IFU and the LSU.
// A single transaction is in flight at a time. The LSU normally wins
// arbitration. A starvation counter forces an IFU grant after STARVE_LIMIT
// consecutive LSU wins during which the IFU was waiting.
//
// Handshake semantics: a request transfers on a cycle where *_req_valid and
// *_req_ready are both 1. *_req_ready is a combinational function of the
// valids in IDLE and is 0 in every other state. mem_req_valid is held with
// stable fields until mem_req_ready. Responses (*_resp_valid,
// mem_resp_valid) are one-cycle pulses with no back-pressure.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  input  logic [63:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [63:0] ifu_resp_data,
  input  logic        lsu_req_valid,
  input  logic [63:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [63:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_len,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_resp_data,
  output logic        lsu_resp_err,
  output logic        ifu_resp_err,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [3:0]  mem_req_len,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(RESP_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  len_q, len_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic [7:0]  tmo_q, tmo_d;

  logic ifu_win, lsu_win, lsu_len_ok, lsu_illegal;
  logic wait_resp, wait_timeout;

  // Arbitration and WAIT exit conditions
  always_comb begin
    lsu_len_ok   = (lsu_req_len == 4'd1) || (lsu_req_len == 4'd2) ||
                   (lsu_req_len == 4'd4) || (lsu_req_len == 4'd8);
    lsu_illegal  = lsu_req_wen && !lsu_len_ok;
    ifu_win      = !rst && (state_q == S_IDLE) && ifu_req_valid &&
                   (!lsu_req_valid || (starve_q == STARVE_MAX));
    lsu_win      = !rst && (state_q == S_IDLE) && lsu_req_valid && !ifu_win;
    wait_resp    = (state_q == S_WAIT) && mem_resp_valid;
    wait_timeout = (state_q == S_WAIT) && !mem_resp_valid && (tmo_q == TMO_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; illegal stores skip the backend entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_win)                    state_d = S_ISSUE;
        else if (lsu_win && lsu_illegal) state_d = S_RESP;
        else if (lsu_win)               state_d = S_ISSUE;
      end
      S_ISSUE: if (mem_req_ready)              state_d = S_WAIT;
      S_WAIT:  if (wait_resp || wait_timeout)  state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, response capture, timeout and starvation counters
  always_comb begin
    starve_d    = starve_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    tmo_d       = (state_q == S_WAIT) ? tmo_q + 8'd1 : 8'd0;

    if (state_q == S_IDLE) begin
      if (ifu_win)
        starve_d = 4'd0;
      else if (lsu_win && ifu_req_valid)
        starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
      else if (!ifu_req_valid)
        starve_d = 4'd0;
    end

    if (ifu_win) begin
      owner_lsu_d = 1'b0;
      addr_d      = ifu_req_addr;
      wen_d       = 1'b0;
      wdata_d     = 64'd0;
      len_d       = 4'd8;
      err_d       = 1'b0;
      rdata_d     = 64'd0;
    end else if (lsu_win) begin
      owner_lsu_d = 1'b1;
      addr_d      = lsu_req_addr;
      wen_d       = lsu_req_wen;
      wdata_d     = lsu_req_wdata;
      len_d       = lsu_req_wen ? lsu_req_len : 4'd8;
      err_d       = lsu_illegal;
      rdata_d     = 64'd0;
    end

    // Stores always return zero data, whatever the backend drives
    if (wait_resp) begin
      rdata_d = wen_q ? 64'd0 : mem_resp_data;
      err_d   = 1'b0;
    end else if (wait_timeout) begin
      rdata_d = 64'd0;
      err_d   = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= 4'd0;
      owner_lsu_q <= 1'b0;
      addr_q      <= 64'd0;
      wen_q       <= 1'b0;
      wdata_q     <= 64'd0;
      len_q       <= 4'd0;
      err_q       <= 1'b0;
      rdata_q     <= 64'd0;
      tmo_q       <= 8'd0;
    end else begin
      starve_q    <= starve_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      tmo_q       <= tmo_d;
    end
  end

  // Outputs decoded from state and the captured transaction
  always_comb begin
    ifu_req_ready  = ifu_win;
    lsu_req_ready  = lsu_win;
    mem_req_valid  = (state_q == S_ISSUE);
    mem_req_addr   = addr_q;
    mem_req_wen    = wen_q;
    mem_req_wdata  = wdata_q;
    mem_req_len    = len_q;
    ifu_resp_valid = (state_q == S_RESP) && !owner_lsu_q;
    lsu_resp_valid = (state_q == S_RESP) && owner_lsu_q;
    ifu_resp_err   = ifu_resp_valid && err_q;
    lsu_resp_err   = lsu_resp_valid && err_q;
    ifu_resp_data  = owner_lsu_q ? 64'd0 : rdata_q;
    lsu_resp_data  = owner_lsu_q ? rdata_q : 64'd0;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// traffic against a byte-level memory reference model.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int RESP_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [63:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [3:0]  lsu_req_len;
  logic        mem_req_valid, mem_req_wen, mem_req_ready, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_len;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ref_mem [logic [63:0]];
  logic [7:0] be_mem  [logic [63:0]];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_len(lsu_req_len), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
    .ifu_resp_err(ifu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_len(mem_req_len), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .dbg_state(dbg_state)
  );

  // Initial memory contents seen by both the backend and the reference
  function automatic logic [7:0] dflt(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = ref_mem.exists(a + 64'(i)) ? ref_mem[a + 64'(i)] : dflt(a + 64'(i));
    return r;
  endfunction

  function automatic logic [63:0] be_read(input logic [63:0] a);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = be_mem.exists(a + 64'(i)) ? be_mem[a + 64'(i)] : dflt(a + 64'(i));
    return r;
  endfunction

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return {$urandom, $urandom};
    return 64'h8000_0000 + 64'($urandom_range(0, 31));
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_req_addr = '0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_len = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic test_reset();
    logic [6:0]   got_ctrl;
    logic [255:0] got_data;
    idle_inputs();
    rst = 1;
    tick(); tick();
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    got_ctrl = {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                ifu_resp_err, lsu_resp_err, mem_req_valid};
    n_vec++;
    if (got_ctrl !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000000", got_ctrl);
    end
    got_data = {ifu_resp_data, lsu_resp_data, mem_req_addr, mem_req_wdata};
    n_vec++;
    if (got_data !== 256'b0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", got_data);
    end
    tick();
    idle_inputs();
    rst = 0;
    #1;
    got_ctrl = {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                ifu_resp_err, lsu_resp_err, mem_req_valid};
    n_vec++;
    if (got_ctrl !== 7'b0) begin
      n_err++; $display("FAIL post_reset_ctrl: got %b expected 0000000", got_ctrl);
    end
  endtask

  task automatic test_single_ifu();
    logic [63:0] d = 64'h1122_3344_5566_7788;
    tick();
    ifu_req_valid = 1; ifu_req_addr = 64'h8000_0000;
    #1;
    n_vec++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_err++; $display("FAIL single_grant: got %b expected 10", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    #1;
    n_vec++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len} !== {1'b1, 64'h8000_0000, 1'b0, 4'd8}) begin
      n_err++; $display("FAIL single_memreq: got v=%b a=%h w=%b l=%0d expected v=1 a=80000000 w=0 l=8",
                        mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len);
    end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = d;
    #1;
    n_vec++;
    if (ifu_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_early_resp: got %b expected 0", ifu_resp_valid);
    end
    tick();
    mem_resp_valid = 0; mem_resp_data = '0;
    #1;
    n_vec++;
    if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid, ifu_resp_data} !== {3'b100, d}) begin
      n_err++; $display("FAIL single_resp: got v=%b e=%b lv=%b d=%h expected v=1 e=0 lv=0 d=%h",
                        ifu_resp_valid, ifu_resp_err, lsu_resp_valid, ifu_resp_data, d);
    end
    tick();
    #1;
    n_vec++;
    if (ifu_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_pulse_width: got %b expected 0", ifu_resp_valid);
    end
  endtask

  task automatic test_starvation();
    bit grants[$];
    bit resp_next = 0;
    int cyc = 0;
    while (grants.size() < 10 && cyc < 200) begin
      tick();
      ifu_req_valid = 1; ifu_req_addr = rand_addr();
      lsu_req_valid = 1; lsu_req_addr = rand_addr(); lsu_req_wen = 0;
      mem_req_ready = 1; mem_resp_valid = resp_next; mem_resp_data = {$urandom, $urandom};
      #1;
      n_vec++;
      if (ifu_req_ready && lsu_req_ready) begin
        n_err++; $display("FAIL starve_both_ready: got 11 expected one-hot");
      end
      if (ifu_req_ready) grants.push_back(1'b1);
      else if (lsu_req_ready) grants.push_back(1'b0);
      resp_next = mem_req_valid && mem_req_ready;
      cyc++;
    end
    n_vec++;
    if (grants.size() != 10) begin
      n_err++; $display("FAIL starve_grant_count: got %0d expected 10", grants.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      n_vec++;
      if (grants[k] !== ((k % 5) == 4)) begin
        n_err++; $display("FAIL starve_pattern[%0d]: got %s expected %s", k,
                          grants[k] ? "I" : "L", ((k % 5) == 4) ? "I" : "L");
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      ifu_req_valid = 0; lsu_req_valid = 0;
      mem_req_ready = 1; mem_resp_valid = resp_next;
      #1;
      resp_next = mem_req_valid && mem_req_ready;
    end
    idle_inputs();
  endtask

  task automatic test_illegal_len();
    int mem_seen = 0, resp_cnt = 0, at = -1;
    logic err_s = 0;
    logic [63:0] data_s = '1;
    tick();
    lsu_req_valid = 1; lsu_req_addr = rand_addr(); lsu_req_wen = 1;
    lsu_req_wdata = {$urandom, $urandom}; lsu_req_len = 4'd3;
    #1;
    n_vec++;
    if ({lsu_req_ready, mem_req_valid} !== 2'b10) begin
      n_err++; $display("FAIL illegal_accept: got rdy=%b mv=%b expected rdy=1 mv=0", lsu_req_ready, mem_req_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      lsu_req_valid = 0; mem_req_ready = 1;
      #1;
      if (mem_req_valid) mem_seen++;
      if (lsu_resp_valid) begin
        resp_cnt++; at = i; err_s = lsu_resp_err; data_s = lsu_resp_data;
      end
    end
    n_vec++;
    if (mem_seen != 0) begin
      n_err++; $display("FAIL illegal_no_memreq: got %0d cycles of mem_req_valid expected 0", mem_seen);
    end
    n_vec++;
    if (resp_cnt != 1 || at < 1 || at > 2) begin
      n_err++; $display("FAIL illegal_resp_count: got %0d pulses at %0d expected 1 pulse at 1..2", resp_cnt, at);
    end
    n_vec++;
    if ({err_s, data_s} !== {1'b1, 64'd0}) begin
      n_err++; $display("FAIL illegal_resp_err: got err=%b data=%h expected err=1 data=0", err_s, data_s);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [63:0] a = rand_addr();
    logic [63:0] d = {$urandom, $urandom};
    int hs = 0, resps = 0;
    logic [63:0] got_d = '0;
    tick();
    lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = 0; lsu_req_len = 4'd2;
    #1;
    n_vec++;
    if (lsu_req_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_accept: got %b expected 1", lsu_req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      lsu_req_valid = 0; lsu_req_addr = rand_addr(); mem_req_ready = 0;
      #1;
      n_vec++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len} !== {1'b1, a, 1'b0, 4'd8}) begin
        n_err++; $display("FAIL bp_stable[%0d]: got v=%b a=%h w=%b l=%0d expected v=1 a=%h w=0 l=8",
                          i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_len, a);
      end
    end
    tick();
    mem_req_ready = 1;
    #1;
    if (mem_req_valid && mem_req_ready) hs++;
    for (int j = 0; j < 8; j++) begin
      tick();
      mem_req_ready = 1; mem_resp_valid = (j == 1); mem_resp_data = d;
      #1;
      if (mem_req_valid && mem_req_ready) hs++;
      if (lsu_resp_valid) begin resps++; got_d = lsu_resp_data; end
    end
    n_vec++;
    if (hs != 1) begin
      n_err++; $display("FAIL bp_handshakes: got %0d expected 1", hs);
    end
    n_vec++;
    if (resps != 1 || got_d !== d) begin
      n_err++; $display("FAIL bp_resp: got %0d pulses data %h expected 1 pulse data %h", resps, got_d, d);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int at = -1, pulses = 0;
    bit seen = 0;
    logic err_s = 0;
    logic [63:0] data_s = '1;
    tick();
    ifu_req_valid = 1; ifu_req_addr = rand_addr();
    #1;
    n_vec++;
    if (ifu_req_ready !== 1'b1) begin
      n_err++; $display("FAIL tmo_accept: got %b expected 1", ifu_req_ready);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      ifu_req_valid = 0; mem_req_ready = 1;
      mem_resp_valid = seen && (i == at + 1); mem_resp_data = 64'hDEAD_BEEF_0BAD_F00D;
      #1;
      if (ifu_resp_valid || lsu_resp_valid) pulses++;
      if (ifu_resp_valid && !seen) begin
        seen = 1; at = i; err_s = ifu_resp_err; data_s = ifu_resp_data;
      end
    end
    n_vec++;
    if (at != RESP_TIMEOUT + 2) begin
      n_err++; $display("FAIL tmo_latency: got %0d expected %0d", at, RESP_TIMEOUT + 2);
    end
    n_vec++;
    if ({err_s, data_s} !== {1'b1, 64'd0}) begin
      n_err++; $display("FAIL tmo_err: got err=%b data=%h expected err=1 data=0", err_s, data_s);
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL tmo_late_ignored: got %0d pulses expected 1", pulses);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    int stale = 0, n_ifu = 0, n_lsu = 0;
    bit acc = 0, hs_prev = 0;
    logic [63:0] d = {$urandom, $urandom};
    logic [63:0] got_d = '0;
    tick();
    lsu_req_valid = 1; lsu_req_addr = rand_addr(); lsu_req_wen = 0;
    #1;
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    #1;
    tick();
    mem_req_ready = 0; rst = 1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      rst = 0; mem_resp_valid = (i == 0); mem_resp_data = {$urandom, $urandom};
      #1;
      if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_err++; $display("FAIL rstwait_no_resp: got %0d active cycles expected 0", stale);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      ifu_req_valid = !acc; ifu_req_addr = 64'h8000_0040;
      mem_req_ready = 1; mem_resp_valid = hs_prev; mem_resp_data = d;
      #1;
      if (ifu_req_ready) acc = 1;
      hs_prev = mem_req_valid && mem_req_ready;
      if (ifu_resp_valid) begin n_ifu++; got_d = ifu_resp_data; end
      if (lsu_resp_valid) n_lsu++;
    end
    n_vec++;
    if (!acc || n_ifu != 1 || n_lsu != 0 || got_d !== d) begin
      n_err++; $display("FAIL rstwait_recover: got acc=%0d ifu=%0d lsu=%0d data=%h expected acc=1 ifu=1 lsu=0 data=%h",
                        acc, n_ifu, n_lsu, got_d, d);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit ifu_pend = 0, lsu_pend = 0, lsu_w = 0;
    logic [63:0] ifu_a = '0, lsu_a = '0, lsu_d = '0;
    logic [3:0]  lsu_l = '0;
    bit m_out = 0, m_due = 0, m_lsu = 0, m_legal = 0, m_issued = 0, m_err = 0, m_wen = 0;
    logic [63:0] m_addr = '0, m_wdata = '0, m_data = '0;
    logic [3:0]  m_len = '0;
    int m_starve = 0;
    bit be_pend = 0;
    int be_cnt = 0;
    logic [63:0] be_data = '0;
    bit idle, e_iw, e_lw, e_mv;
    logic [3:0] len_tab [12];
    len_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd3, 4'd5, 4'd12};
    for (int i = 0; i < 3; i++) tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!ifu_pend && $urandom_range(0, 2) == 0) begin
        ifu_pend = 1; ifu_a = rand_addr();
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1; lsu_a = rand_addr(); lsu_w = 1'($urandom_range(0, 1));
        lsu_d = {$urandom, $urandom}; lsu_l = len_tab[$urandom_range(0, 11)];
      end
      ifu_req_valid = ifu_pend; ifu_req_addr = ifu_pend ? ifu_a : {$urandom, $urandom};
      lsu_req_valid = lsu_pend; lsu_req_addr = lsu_a; lsu_req_wen = lsu_w;
      lsu_req_wdata = lsu_d; lsu_req_len = lsu_l;
      mem_req_ready = 1'($urandom_range(0, 1));
      if (be_pend && be_cnt == 0) begin
        mem_resp_valid = 1; mem_resp_data = be_data;
      end else begin
        mem_resp_valid = !be_pend && ($urandom_range(0, 7) == 0);
        mem_resp_data = {$urandom, $urandom};
      end
      #1;
      idle = !m_out && !m_due;
      e_iw = idle && ifu_pend && (!lsu_pend || m_starve == STARVE_LIMIT);
      e_lw = idle && lsu_pend && !e_iw;
      e_mv = m_out && m_legal && !m_issued;

      n_vec++;
      if ({ifu_req_ready, lsu_req_ready} !== {e_iw, e_lw}) begin
        n_err++; $display("FAIL rnd_grant@%0d: got %b%b expected %b%b", cyc,
                          ifu_req_ready, lsu_req_ready, e_iw, e_lw);
      end
      n_vec++;
      if ({ifu_resp_valid, lsu_resp_valid} !== {m_due && !m_lsu, m_due && m_lsu}) begin
        n_err++; $display("FAIL rnd_resp_valid@%0d: got %b%b expected %b%b", cyc,
                          ifu_resp_valid, lsu_resp_valid, m_due && !m_lsu, m_due && m_lsu);
      end
      if (m_due) begin
        n_vec++;
        if (m_lsu ? ({lsu_resp_err, lsu_resp_data} !== {m_err, m_data})
                  : ({ifu_resp_err, ifu_resp_data} !== {m_err, m_data})) begin
          n_err++; $display("FAIL rnd_resp_data@%0d: got ierr=%b idata=%h lerr=%b ldata=%h expected %s err=%b data=%h",
                            cyc, ifu_resp_err, ifu_resp_data, lsu_resp_err, lsu_resp_data,
                            m_lsu ? "lsu" : "ifu", m_err, m_data);
        end
      end
      n_vec++;
      if (mem_req_valid !== e_mv) begin
        n_err++; $display("FAIL rnd_memvalid@%0d: got %b expected %b", cyc, mem_req_valid, e_mv);
      end
      if (e_mv && mem_req_valid) begin
        n_vec++;
        if ({mem_req_addr, mem_req_wen, mem_req_len} !== {m_addr, m_wen, m_wen ? m_len : 4'd8} ||
            (m_wen && mem_req_wdata !== m_wdata)) begin
          n_err++; $display("FAIL rnd_memreq@%0d: got a=%h w=%b l=%0d d=%h expected a=%h w=%b l=%0d d=%h",
                            cyc, mem_req_addr, mem_req_wen, mem_req_len, mem_req_wdata,
                            m_addr, m_wen, m_wen ? m_len : 4'd8, m_wdata);
        end
      end

      if (m_due) begin m_out = 0; m_due = 0; end
      if (be_pend) begin
        if (be_cnt == 0) begin be_pend = 0; m_due = 1; end
        else be_cnt--;
      end
      if (mem_req_valid && mem_req_ready) begin
        be_pend = 1; be_cnt = $urandom_range(0, 4);
        if (mem_req_wen) begin
          for (int i = 0; i < int'(mem_req_len) && i < 8; i++)
            be_mem[mem_req_addr + 64'(i)] = mem_req_wdata[8*i +: 8];
          be_data = {$urandom, $urandom};
        end else begin
          be_data = be_read(mem_req_addr);
        end
      end
      if (e_mv && mem_req_ready) m_issued = 1;
      if (idle && !ifu_pend) m_starve = 0;
      if (e_iw) begin
        m_out = 1; m_lsu = 0; m_legal = 1; m_issued = 0; m_wen = 0;
        m_addr = ifu_a; m_len = 4'd8; m_wdata = '0;
        m_data = ref_read(ifu_a); m_err = 0;
        ifu_pend = 0; m_starve = 0;
      end else if (e_lw) begin
        m_out = 1; m_lsu = 1; m_issued = 0; m_wen = lsu_w;
        m_addr = lsu_a; m_len = lsu_l; m_wdata = lsu_d;
        m_legal = !lsu_w || lsu_l == 4'd1 || lsu_l == 4'd2 || lsu_l == 4'd4 || lsu_l == 4'd8;
        m_err = !m_legal;
        if (!lsu_w) m_data = ref_read(lsu_a);
        else begin
          m_data = '0;
          if (m_legal)
            for (int i = 0; i < int'(lsu_l); i++) ref_mem[lsu_a + 64'(i)] = lsu_d[8*i +: 8];
        end
        if (!m_legal) m_due = 1;
        if (ifu_pend) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        lsu_pend = 0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_ifu();
    test_starvation();
    test_illegal_len();
    test_backpressure();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
